wb_commit_multi: RTL and testbench



---
 rtl/wb_commit_multi.sv | 240 ++++++++++++++++++++++++
 tb/tb_wb_commit_multi.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_commit_multi.sv
`default_nettype none
// ============================================================================
//  Module   : wb_commit_multi
//  Purpose  : Multi-lane writeback / commit stage. Accepts one bundle of up
//             to LANES in-order instructions per cycle, resolves the oldest
//             redirect and squashes younger lanes, merges same-register
//             writes, issues one CSR write, and queues one commit record per
//             surviving lane for the commit consumer.
//  Ports    : clk, rst (async, active-high)
//             in_*         : bundle handshake and per-lane packed fields
//             rf_*         : registered register-file write port (per lane)
//             csr_*        : registered CSR write port plus conflict pulse
//             redirect_*   : registered one-cycle redirect
//             commit_*     : head of the commit queue, cq_count occupancy
//  Revision : 1.0  initial release
// ============================================================================
module wb_commit_multi #(
  parameter int XLEN     = 64,
  parameter int LANES    = 2,
  parameter int CQ_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES-1:0]             in_lane_valid,
  input  logic [LANES-1:0]             in_is_wb,
  input  logic [LANES-1:0]             in_is_mem_read,
  input  logic [LANES-1:0]             in_is_jump,
  input  logic [LANES-1:0]             in_is_branch,
  input  logic [LANES-1:0]             in_br_taken,
  input  logic [LANES-1:0]             in_is_csr,
  input  logic [LANES*5-1:0]           in_wd,
  input  logic [LANES*XLEN-1:0]        in_alu_out,
  input  logic [LANES*XLEN-1:0]        in_mem_out,
  input  logic [LANES*XLEN-1:0]        in_pc_plus4,
  input  logic [LANES*XLEN-1:0]        in_pc,
  input  logic [LANES*32-1:0]          in_instr,
  input  logic [LANES*12-1:0]          in_csr_addr,
  input  logic [LANES*XLEN-1:0]        in_csr_val,
  output logic [LANES-1:0]             rf_we,
  output logic [LANES*5-1:0]           rf_wa,
  output logic [LANES*XLEN-1:0]        rf_wdata,
  output logic                         csr_we,
  output logic [11:0]                  csr_addr,
  output logic [XLEN-1:0]              csr_data,
  output logic                         csr_conflict,
  output logic                         redirect_valid,
  output logic [XLEN-1:0]              redirect_addr,
  output logic                         commit_valid,
  input  logic                         commit_ready,
  output logic [XLEN-1:0]              commit_pc,
  output logic [31:0]                  commit_instr,
  output logic [4:0]                   commit_wd,
  output logic [XLEN-1:0]              commit_wdata,
  output logic                         commit_is_wb,
  output logic                         commit_is_mem,
  output logic [$clog2(CQ_DEPTH):0]    cq_count
);

  localparam int c_PW = (CQ_DEPTH > 1) ? $clog2(CQ_DEPTH) : 1;
  localparam int c_CW = $clog2(CQ_DEPTH) + 1;

  // --------------------------------------------------------------------------
  // Bundle decode
  // --------------------------------------------------------------------------
  logic [LANES-1:0]      w_surv;
  logic [LANES-1:0]      w_wrCand;
  logic [LANES-1:0]      w_rfWe;
  logic [LANES-1:0]      w_recWb;
  logic [LANES*XLEN-1:0] w_wdata;
  logic                  w_anyRedir;
  logic [XLEN-1:0]       w_redirAddr;
  logic                  w_csrWe;
  logic                  w_csrConflict;
  logic [11:0]           w_csrAddr;
  logic [XLEN-1:0]       w_csrData;
  logic [c_PW-1:0]       w_pos  [LANES];
  logic [c_PW-1:0]       w_slot [LANES];
  logic [c_CW-1:0]       w_pushCnt;
  logic                  w_accept;
  logic                  w_pop;

  logic [c_PW-1:0]       r_head;
  logic [c_PW-1:0]       r_tail;
  logic [c_CW-1:0]       r_count;

  // Oldest redirect wins; once seen, every younger lane is squashed.
  always_comb begin
    w_anyRedir  = 1'b0;
    w_redirAddr = '0;
    w_surv      = '0;
    for (int i = 0; i < LANES; i++) begin
      w_surv[i] = in_lane_valid[i] & ~w_anyRedir;
      if (in_lane_valid[i] && !w_anyRedir &&
          (in_is_jump[i] || (in_is_branch[i] && in_br_taken[i]))) begin
        w_anyRedir  = 1'b1;
        w_redirAddr = {in_alu_out[i*XLEN+1 +: XLEN-1], 1'b0};
      end
    end
  end

  generate
    for (genvar g = 0; g < LANES; g++) begin : g_lane
      assign w_wdata[g*XLEN +: XLEN] =
          in_is_mem_read[g] ? in_mem_out[g*XLEN +: XLEN]  :
          in_is_jump[g]     ? in_pc_plus4[g*XLEN +: XLEN] :
                              in_alu_out[g*XLEN +: XLEN];
      // x0 targets still retire but never touch the register file.
      assign w_recWb[g]  = in_is_wb[g] & (in_wd[g*5 +: 5] != 5'd0);
      assign w_wrCand[g] = w_surv[g] & w_recWb[g];
      assign w_slot[g]   = r_tail + w_pos[g];
    end
  endgenerate

  // Write-after-write merge: a write is dropped if any younger surviving lane
  // writes the same register in this bundle.
  always_comb begin
    w_rfWe = w_wrCand;
    for (int i = 0; i < LANES; i++) begin
      for (int j = i + 1; j < LANES; j++) begin
        if (w_wrCand[j] && (in_wd[j*5 +: 5] == in_wd[i*5 +: 5])) begin
          w_rfWe[i] = 1'b0;
        end
      end
    end
  end

  // Single CSR port: oldest surviving CSR lane wins, the rest flag a conflict.
  always_comb begin
    w_csrWe       = 1'b0;
    w_csrConflict = 1'b0;
    w_csrAddr     = '0;
    w_csrData     = '0;
    for (int i = 0; i < LANES; i++) begin
      if (w_surv[i] && in_is_csr[i]) begin
        if (w_csrWe) begin
          w_csrConflict = 1'b1;
        end else begin
          w_csrWe   = 1'b1;
          w_csrAddr = in_csr_addr[i*12 +: 12];
          w_csrData = in_csr_val[i*XLEN +: XLEN];
        end
      end
    end
  end

  // Surviving lanes may be non-contiguous, so each gets a compacted offset
  // from the tail equal to the number of older survivors.
  always_comb begin
    w_pushCnt = '0;
    for (int i = 0; i < LANES; i++) begin
      w_pos[i] = w_pushCnt[c_PW-1:0];
      if (w_surv[i]) begin
        w_pushCnt = w_pushCnt + c_CW'(1);
      end
    end
  end

  // Conservative: space for a full bundle, ignoring any same-cycle pop.
  assign in_ready = (r_count <= c_CW'(CQ_DEPTH - LANES));
  assign w_accept = in_valid & in_ready;
  assign w_pop    = commit_valid & commit_ready;

  // --------------------------------------------------------------------------
  // Registered writeback ports and queue pointers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      rf_we          <= '0;
      rf_wa          <= '0;
      rf_wdata       <= '0;
      csr_we         <= 1'b0;
      csr_addr       <= '0;
      csr_data       <= '0;
      csr_conflict   <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_addr  <= '0;
    end else begin
      rf_we          <= w_accept ? w_rfWe : '0;
      csr_we         <= w_accept & w_csrWe;
      csr_conflict   <= w_accept & w_csrConflict;
      redirect_valid <= w_accept & w_anyRedir;
      if (w_accept) begin
        rf_wa    <= in_wd;
        rf_wdata <= w_wdata;
        r_tail   <= r_tail + w_pushCnt[c_PW-1:0];
        if (w_csrWe) begin
          csr_addr <= w_csrAddr;
          csr_data <= w_csrData;
        end
        if (w_anyRedir) begin
          redirect_addr <= w_redirAddr;
        end
      end
      if (w_pop) begin
        r_head <= r_head + c_PW'(1);
      end
      r_count <= r_count + (w_accept ? w_pushCnt : '0) - c_CW'(w_pop);
    end
  end

  // --------------------------------------------------------------------------
  // Commit queue storage (contents are only meaningful below r_count)
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] r_mPc    [CQ_DEPTH];
  logic [31:0]     r_mInstr [CQ_DEPTH];
  logic [4:0]      r_mWd    [CQ_DEPTH];
  logic [XLEN-1:0] r_mWdata [CQ_DEPTH];
  logic            r_mWb    [CQ_DEPTH];
  logic            r_mMem   [CQ_DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (w_accept && w_surv[i]) begin
        r_mPc[w_slot[i]]    <= in_pc[i*XLEN +: XLEN];
        r_mInstr[w_slot[i]] <= in_instr[i*32 +: 32];
        r_mWd[w_slot[i]]    <= in_wd[i*5 +: 5];
        r_mWdata[w_slot[i]] <= w_wdata[i*XLEN +: XLEN];
        r_mWb[w_slot[i]]    <= w_recWb[i];
        r_mMem[w_slot[i]]   <= in_is_mem_read[i];
      end
    end
  end

  // Payload is forced to zero when empty so reset clears every output at once.
  assign commit_valid  = (r_count != '0);
  assign commit_pc     = commit_valid ? r_mPc[r_head]    : '0;
  assign commit_instr  = commit_valid ? r_mInstr[r_head] : '0;
  assign commit_wd     = commit_valid ? r_mWd[r_head]    : '0;
  assign commit_wdata  = commit_valid ? r_mWdata[r_head] : '0;
  assign commit_is_wb  = commit_valid & r_mWb[r_head];
  assign commit_is_mem = commit_valid & r_mMem[r_head];
  assign cq_count      = r_count;

endmodule
`default_nettype wire

// File: tb/tb_wb_commit_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_commit_multi
//  Purpose  : Self-checking bench for wb_commit_multi (LANES=2, CQ_DEPTH=8)
//             using a queue-based reference model of retire behaviour.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wb_commit_multi;
  localparam int XLEN = 64;
  localparam int LANES = 2;
  localparam int CQ_DEPTH = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                  in_valid, in_ready;
  logic [LANES-1:0]      in_lane_valid, in_is_wb, in_is_mem_read, in_is_jump;
  logic [LANES-1:0]      in_is_branch, in_br_taken, in_is_csr;
  logic [LANES*5-1:0]    in_wd;
  logic [LANES*XLEN-1:0] in_alu_out, in_mem_out, in_pc_plus4, in_pc, in_csr_val;
  logic [LANES*32-1:0]   in_instr;
  logic [LANES*12-1:0]   in_csr_addr;
  logic [LANES-1:0]      rf_we;
  logic [LANES*5-1:0]    rf_wa;
  logic [LANES*XLEN-1:0] rf_wdata;
  logic                  csr_we, csr_conflict, redirect_valid;
  logic [11:0]           csr_addr;
  logic [XLEN-1:0]       csr_data, redirect_addr;
  logic                  commit_valid, commit_ready;
  logic [XLEN-1:0]       commit_pc, commit_wdata;
  logic [31:0]           commit_instr;
  logic [4:0]            commit_wd;
  logic                  commit_is_wb, commit_is_mem;
  logic [$clog2(CQ_DEPTH):0] cq_count;

  wb_commit_multi #(.XLEN(XLEN), .LANES(LANES), .CQ_DEPTH(CQ_DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_lane_valid(in_lane_valid), .in_is_wb(in_is_wb),
    .in_is_mem_read(in_is_mem_read), .in_is_jump(in_is_jump),
    .in_is_branch(in_is_branch), .in_br_taken(in_br_taken),
    .in_is_csr(in_is_csr), .in_wd(in_wd), .in_alu_out(in_alu_out),
    .in_mem_out(in_mem_out), .in_pc_plus4(in_pc_plus4), .in_pc(in_pc),
    .in_instr(in_instr), .in_csr_addr(in_csr_addr), .in_csr_val(in_csr_val),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wdata(rf_wdata),
    .csr_we(csr_we), .csr_addr(csr_addr), .csr_data(csr_data),
    .csr_conflict(csr_conflict), .redirect_valid(redirect_valid),
    .redirect_addr(redirect_addr), .commit_valid(commit_valid),
    .commit_ready(commit_ready), .commit_pc(commit_pc),
    .commit_instr(commit_instr), .commit_wd(commit_wd),
    .commit_wdata(commit_wdata), .commit_is_wb(commit_is_wb),
    .commit_is_mem(commit_is_mem), .cq_count(cq_count)
  );

  typedef struct {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [4:0]      wd;
    logic [XLEN-1:0] wdata;
    logic            isWb;
    logic            isMem;
  } rec_t;

  rec_t mq[$];
  int   total = 0;
  int   bad = 0;
  logic lastAcc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_bundle();
    in_valid = 1'b0; in_lane_valid = '0; in_is_wb = '0; in_is_mem_read = '0;
    in_is_jump = '0; in_is_branch = '0; in_br_taken = '0; in_is_csr = '0;
    in_wd = '0; in_alu_out = '0; in_mem_out = '0; in_pc_plus4 = '0; in_pc = '0;
    in_instr = '0; in_csr_addr = '0; in_csr_val = '0;
  endtask

  task automatic set_lane(input int i, input logic v, input logic wb, input logic mr,
                          input logic jp, input logic br, input logic tk, input logic cs,
                          input logic [4:0] wd, input logic [63:0] alu, input logic [63:0] mo,
                          input logic [63:0] pc4, input logic [63:0] pc,
                          input logic [11:0] ca, input logic [63:0] cv);
    in_lane_valid[i] = v; in_is_wb[i] = wb; in_is_mem_read[i] = mr;
    in_is_jump[i] = jp; in_is_branch[i] = br; in_br_taken[i] = tk; in_is_csr[i] = cs;
    in_wd[i*5 +: 5] = wd; in_alu_out[i*XLEN +: XLEN] = alu;
    in_mem_out[i*XLEN +: XLEN] = mo; in_pc_plus4[i*XLEN +: XLEN] = pc4;
    in_pc[i*XLEN +: XLEN] = pc; in_instr[i*32 +: 32] = $urandom;
    in_csr_addr[i*12 +: 12] = ca; in_csr_val[i*XLEN +: XLEN] = cv;
  endtask

  task automatic rand_bundle();
    logic [63:0] pc;
    in_valid = ($urandom_range(0, 3) != 0);
    for (int i = 0; i < LANES; i++) begin
      pc = {32'h0, $urandom} & ~64'h3;
      set_lane(i, ($urandom_range(0, 4) != 0), ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
               ($urandom_range(0, 4) == 0), $urandom_range(0, 1),
               ($urandom_range(0, 4) == 0), 5'($urandom_range(0, 7)),
               {$urandom, $urandom}, {$urandom, $urandom}, pc + 64'd4, pc,
               12'($urandom), {$urandom, $urandom});
    end
  endtask

  // One clock: check combinational/head state, clock the DUT, update the
  // model and check the registered writeback outputs.
  task automatic cycle();
    logic acc, pop;
    int   r;
    logic [LANES-1:0] surv, wr, we;
    logic [63:0] wdv [LANES];
    logic eCsrWe, eConf;
    logic [11:0] eCsrA;
    logic [63:0] eCsrD, eRa;
    int   ncsr;
    rec_t rec;
    #2;
    chk("in_ready", in_ready, mq.size() <= CQ_DEPTH - LANES);
    chk("cq_count", cq_count, mq.size());
    chk("commit_valid", commit_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("commit_pc", commit_pc, mq[0].pc);
      chk("commit_instr", commit_instr, mq[0].instr);
      chk("commit_wd", commit_wd, mq[0].wd);
      chk("commit_wdata", commit_wdata, mq[0].wdata);
      chk("commit_is_wb", commit_is_wb, mq[0].isWb);
      chk("commit_is_mem", commit_is_mem, mq[0].isMem);
    end
    acc = in_valid && (mq.size() <= CQ_DEPTH - LANES);
    pop = (mq.size() != 0) && commit_ready;

    r = -1;
    for (int i = 0; i < LANES; i++)
      if (r < 0 && in_lane_valid[i] && (in_is_jump[i] || (in_is_branch[i] && in_br_taken[i])))
        r = i;
    eRa = (r >= 0) ? (in_alu_out[r*XLEN +: XLEN] & ~64'h1) : 64'h0;
    ncsr = 0; eCsrA = '0; eCsrD = '0;
    for (int i = 0; i < LANES; i++) begin
      surv[i] = in_lane_valid[i] && (r < 0 || i <= r);
      wdv[i] = in_is_mem_read[i] ? in_mem_out[i*XLEN +: XLEN] :
               in_is_jump[i] ? in_pc_plus4[i*XLEN +: XLEN] : in_alu_out[i*XLEN +: XLEN];
      wr[i] = surv[i] && in_is_wb[i] && in_wd[i*5 +: 5] != 0;
      if (surv[i] && in_is_csr[i]) begin
        if (ncsr == 0) begin eCsrA = in_csr_addr[i*12 +: 12]; eCsrD = in_csr_val[i*XLEN +: XLEN]; end
        ncsr++;
      end
    end
    for (int i = 0; i < LANES; i++) begin
      we[i] = wr[i];
      for (int j = 0; j < LANES; j++)
        if (j > i && wr[j] && in_wd[j*5 +: 5] == in_wd[i*5 +: 5]) we[i] = 1'b0;
    end
    eCsrWe = acc && ncsr > 0;
    eConf  = acc && ncsr > 1;

    @(posedge clk); #1;
    lastAcc = acc;
    if (pop) void'(mq.pop_front());
    if (acc) begin
      for (int i = 0; i < LANES; i++) begin
        if (surv[i]) begin
          rec.pc = in_pc[i*XLEN +: XLEN]; rec.instr = in_instr[i*32 +: 32];
          rec.wd = in_wd[i*5 +: 5]; rec.wdata = wdv[i];
          rec.isWb = in_is_wb[i] && in_wd[i*5 +: 5] != 0; rec.isMem = in_is_mem_read[i];
          mq.push_back(rec);
        end
      end
    end
    chk("rf_we", rf_we, acc ? we : '0);
    for (int i = 0; i < LANES; i++) begin
      if (acc && we[i]) begin
        chk("rf_wa", rf_wa[i*5 +: 5], in_wd[i*5 +: 5]);
        chk("rf_wdata", rf_wdata[i*XLEN +: XLEN], wdv[i]);
      end
    end
    chk("csr_we", csr_we, eCsrWe);
    if (eCsrWe) begin
      chk("csr_addr", csr_addr, eCsrA);
      chk("csr_data", csr_data, eCsrD);
    end
    chk("csr_conflict", csr_conflict, eConf);
    chk("redirect_valid", redirect_valid, acc && r >= 0);
    if (acc && r >= 0) chk("redirect_addr", redirect_addr, eRa);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rf_we"}, rf_we, 0);
    chk({tag, "_rf_wa"}, rf_wa, 0);
    chk({tag, "_rf_wdata"}, rf_wdata[63:0], 0);
    chk({tag, "_csr_we"}, csr_we, 0);
    chk({tag, "_csr_addr"}, csr_addr, 0);
    chk({tag, "_csr_conflict"}, csr_conflict, 0);
    chk({tag, "_redirect_valid"}, redirect_valid, 0);
    chk({tag, "_redirect_addr"}, redirect_addr, 0);
    chk({tag, "_commit_valid"}, commit_valid, 0);
    chk({tag, "_commit_pc"}, commit_pc, 0);
    chk({tag, "_cq_count"}, cq_count, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
  endtask

  task automatic two_alu(input logic [63:0] pc);
    clear_bundle();
    in_valid = 1'b1;
    set_lane(0, 1, 1, 0, 0, 0, 0, 0, 5'd9,  pc + 64'h11, 0, pc + 64'd4, pc, 0, 0);
    set_lane(1, 1, 1, 0, 0, 0, 0, 0, 5'd10, pc + 64'h22, 0, pc + 64'd8, pc + 64'd4, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    commit_ready = 1'b0;
    lastAcc = 1'b0;
    clear_bundle();
    #1;
    check_zero("reset");
    #12 rst = 1'b0;
    @(posedge clk); #1;

    // Basic retire: addi x5 + load x6, then pop both.
    in_valid = 1'b1;
    set_lane(0, 1, 1, 0, 0, 0, 0, 0, 5'd5, 64'h10, 64'h0, 64'h104, 64'h100, 0, 0);
    set_lane(1, 1, 1, 1, 0, 0, 0, 0, 5'd6, 64'h0, 64'hAB, 64'h108, 64'h104, 0, 0);
    cycle();
    chk("basic_rf_we", rf_we, 2'b11);
    chk("basic_wdata1", rf_wdata[127:64], 64'hAB);
    clear_bundle();
    commit_ready = 1'b1;
    cycle(); cycle(); cycle();

    // Redirect squash: jal x1 in lane 0, addi x7 squashed.
    in_valid = 1'b1;
    set_lane(0, 1, 1, 0, 1, 0, 0, 0, 5'd1, 64'h2001, 0, 64'h1004, 64'h1000, 0, 0);
    set_lane(1, 1, 1, 0, 0, 0, 0, 0, 5'd7, 64'h77, 0, 64'h1008, 64'h1004, 0, 0);
    commit_ready = 1'b0;
    cycle();
    chk("redir_addr", redirect_addr, 64'h2000);
    chk("redir_rf_we", rf_we, 2'b01);
    clear_bundle();
    cycle();
    chk("redir_one_record", cq_count, 1);
    commit_ready = 1'b1;
    cycle();

    // WAW on x3, then x0 write.
    in_valid = 1'b1;
    set_lane(0, 1, 1, 0, 0, 0, 0, 0, 5'd3, 64'h1, 0, 64'h204, 64'h200, 0, 0);
    set_lane(1, 1, 1, 0, 0, 0, 0, 0, 5'd3, 64'h2, 0, 64'h208, 64'h204, 0, 0);
    cycle();
    chk("waw_rf_we", rf_we, 2'b10);
    set_lane(0, 1, 1, 0, 0, 0, 0, 0, 5'd0, 64'h5, 0, 64'h20c, 64'h208, 0, 0);
    set_lane(1, 0, 0, 0, 0, 0, 0, 0, 5'd0, 64'h0, 0, 64'h0, 64'h0, 0, 0);
    cycle();
    chk("x0_rf_we", rf_we, 2'b00);
    clear_bundle();
    for (int k = 0; k < 4; k++) cycle();

    // CSR conflict.
    in_valid = 1'b1;
    set_lane(0, 1, 0, 0, 0, 0, 0, 1, 5'd0, 0, 0, 64'h304, 64'h300, 12'h300, 64'hAAA);
    set_lane(1, 1, 0, 0, 0, 0, 0, 1, 5'd0, 0, 0, 64'h308, 64'h304, 12'h305, 64'hBBB);
    cycle();
    chk("csr_conf_addr", csr_addr, 12'h300);
    clear_bundle();
    cycle();
    chk("csr_conf_pulse_end", csr_conflict, 0);
    for (int k = 0; k < 3; k++) cycle();

    // Fill to 8 with the consumer stalled, then stall upstream.
    commit_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      two_alu(64'h4000 + 64'(b * 8));
      cycle();
    end
    chk("full_count", cq_count, 8);
    two_alu(64'h4020);
    cycle(); cycle();
    chk("full_ready", in_ready, 0);
    // Drain with continuous traffic across pointer wrap.
    commit_ready = 1'b1;
    for (int b = 0; b < 20; b++) begin
      if (lastAcc) two_alu(64'h5000 + 64'(b * 8));
      cycle();
    end

    // Randomised traffic; a stalled bundle is held until accepted.
    lastAcc = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if (lastAcc || !in_valid) rand_bundle();
      commit_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end

    // Async reset with 5 records queued and a redirect pulse active.
    clear_bundle();
    commit_ready = 1'b1;
    for (int k = 0; k < 6; k++) cycle();
    commit_ready = 1'b0;
    two_alu(64'h6000); cycle();
    two_alu(64'h6008); cycle();
    in_valid = 1'b1;
    set_lane(0, 1, 1, 0, 1, 0, 0, 0, 5'd1, 64'h7001, 0, 64'h6014, 64'h6010, 0, 0);
    cycle();
    chk("pre_reset_count", cq_count, 5);
    chk("pre_reset_redirect", redirect_valid, 1);
    clear_bundle();
    #2 rst = 1'b1;
    #1;
    check_zero("async_rst");
    mq.delete();
    @(posedge clk); #1;
    check_zero("rst_held");
    #2 rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_redirect", redirect_valid, 0);
    cycle(); cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
`default_nettype wire
